seg7_display: RTL

Output-port stage downstream of the CPU's display register. On each `display` strobe from the controller, it captures the 8-bit ALU result and converts it to three BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking. The block replaces the bare `data_out` register at the top level.

---
 rtl/nam85_disp_pkg.sv | 52 +++++
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 rtl/seg7_display.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nam85_disp_pkg.sv
// Shared types and constants for the display output stage: conversion FSM
// states, seven-segment glyphs and the double-dabble nibble correction.
package nam85_disp_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } conv_state_e;

   localparam int unsigned NUM_DIGITS = 3;
   localparam int unsigned NUM_SHIFTS = 8;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Active-high {g,f,e,d,c,b,a}; element [0] is the last entry in the list
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b1101111,
      7'b1111111,
      7'b0000111,
      7'b1111101,
      7'b1101101,
      7'b1100110,
      7'b1001111,
      7'b1011011,
      7'b0000110,
      7'b0111111
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] glyph;
      if (digit <= 4'd9) begin
         glyph = SEG_TABLE[digit];
      end else begin
         glyph = SEG_BLANK;
      end
      return glyph;
   endfunction

   function automatic logic [11:0] dd_adjust(input logic [11:0] acc);
      logic [11:0] adj;
      adj = acc;
      for (int i = 0; i < 3; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = acc[4*i +: 4];
         end
      end
      return adj;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one shift
// per cycle) with a one-deep, newest-wins pending request register.
module bin2bcd_seq
   import nam85_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  din,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [7:0]  bin
);

   conv_state_e state_q, state_d;
   logic [7:0]  sreg_q, sreg_d;
   logic [11:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  src_q, src_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_val_q, pend_val_d;
   logic [11:0] bcd_q, bcd_d;
   logic [7:0]  bin_q, bin_d;
   logic        done_q, done_d;
   logic [19:0] shift_s;
   logic [7:0]  next_src_s;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sreg_q     <= 8'd0;
         acc_q      <= 12'd0;
         cnt_q      <= 3'd0;
         src_q      <= 8'd0;
         pend_q     <= 1'b0;
         pend_val_q <= 8'd0;
         bcd_q      <= 12'd0;
         bin_q      <= 8'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         src_q      <= src_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         bcd_q      <= bcd_d;
         bin_q      <= bin_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic: load, shift/adjust, completion and pending chaining
   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      src_d      = src_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      bcd_d      = bcd_q;
      bin_d      = bin_q;
      done_d     = 1'b0;
      shift_s    = {dd_adjust(acc_q), sreg_q} << 1;
      next_src_s = start ? din : pend_val_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               sreg_d  = din;
               src_d   = din;
               acc_d   = 12'd0;
               cnt_d   = 3'd0;
               state_d = CONVERT;
            end else begin
               state_d = IDLE;
            end
         end
         CONVERT: begin
            acc_d  = shift_s[19:8];
            sreg_d = shift_s[7:0];
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               bcd_d  = shift_s[19:8];
               bin_d  = src_q;
               done_d = 1'b1;
               // A strobe on the completion edge is newer than anything pending
               if (start || pend_q) begin
                  sreg_d  = next_src_s;
                  src_d   = next_src_s;
                  acc_d   = 12'd0;
                  cnt_d   = 3'd0;
                  pend_d  = 1'b0;
                  state_d = CONVERT;
               end else begin
                  state_d = IDLE;
               end
            end else if (start) begin
               pend_d     = 1'b1;
               pend_val_d = din;
            end else begin
               pend_d = pend_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == CONVERT);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign bin  = bin_q;

endmodule

// File: rtl/seg7_display.sv
// Display output stage: captures the ALU result on a display strobe, converts
// it to BCD and scans it onto a 3-digit seven-segment display with blanking.
module seg7_display
   import nam85_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 4,
   parameter logic        COMMON_ANODE = 1'b0
)(
   input  logic        clk_out,
   input  logic        rst,
   input  logic        display,
   input  logic [7:0]  data_in,
   output logic        busy,
   output logic [7:0]  value,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic [2:0]  an
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_RST = COMMON_ANODE ? ~7'b0111111 : 7'b0111111;
   localparam logic [2:0] AN_RST  = COMMON_ANODE ? ~3'b001 : 3'b001;

   logic        conv_done_s;
   logic [11:0] bcd_s;
   logic [7:0]  bin_s;

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic [3:0]       digit_s;
   logic             blank_s;
   logic [2:0]       an_raw_s;
   logic [6:0]       seg_raw_s;

   bin2bcd_seq u_conv (
      .clk   (clk_out),
      .rst   (rst),
      .start (display),
      .din   (data_in),
      .busy  (busy),
      .done  (conv_done_s),
      .bcd   (bcd_s),
      .bin   (bin_s)
   );

   // Scan divider, digit index and registered display drive
   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= 2'd0;
         seg_q <= SEG_RST;
         an_q  <= AN_RST;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   // Digit selection, leading-zero blanking and output polarity
   always_comb begin
      div_d     = div_q;
      idx_d     = idx_q;
      digit_s   = bcd_s[3:0];
      blank_s   = 1'b0;
      an_raw_s  = 3'b001;
      seg_raw_s = SEG_BLANK;

      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
         div_d = div_q + DIV_W'(1);
         idx_d = idx_q;
      end

      case (idx_q)
         2'd0: begin
            digit_s  = bcd_s[3:0];
            blank_s  = 1'b0;
            an_raw_s = 3'b001;
         end
         2'd1: begin
            digit_s  = bcd_s[7:4];
            blank_s  = (bcd_s[11:8] == 4'd0) && (bcd_s[7:4] == 4'd0);
            an_raw_s = 3'b010;
         end
         2'd2: begin
            digit_s  = bcd_s[11:8];
            blank_s  = (bcd_s[11:8] == 4'd0);
            an_raw_s = 3'b100;
         end
         default: begin
            digit_s  = bcd_s[3:0];
            blank_s  = 1'b0;
            an_raw_s = 3'b001;
         end
      endcase

      if (blank_s) begin
         seg_raw_s = SEG_BLANK;
      end else begin
         seg_raw_s = seg_encode(digit_s);
      end

      if (COMMON_ANODE) begin
         seg_d = ~seg_raw_s;
         an_d  = ~an_raw_s;
      end else begin
         seg_d = seg_raw_s;
         an_d  = an_raw_s;
      end
   end

   assign value = bin_s;
   assign bcd   = bcd_s;
   assign seg   = seg_q;
   assign an    = an_q;

endmodule
